serial_alu: RTL
===============

Name: serial_alu

Overview:
- Bit-serial ALU/sequencer that drives the register file's scan ports.
- On each accepted command it sweeps a register operand pair NSHIFT bits per cycle, from LSB to MSB.
- Each cycle it takes operand chunks from the register file's scan_out/scan_out2 and returns the result chunk on scan_in, with the operand b chunk recirculated on scan_in2.
- It owns the flags register that the register file reads through its flags input.

Parameters:
- REG_BITS, 8, width of one register.
- NSHIFT, 2, bits processed per cycle; must divide REG_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  command valid; sampled only when ready=1.
- op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MOV(b).
- wide  in  1  1 = 2*REG_BITS operation over a register pair.
- no_wb  in  1  1 = compute flags only and leave operand a unchanged (CMP/TEST).
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle pulse on the last chunk cycle.
- do_scan, do_scan2  out  1  scan enables for regfile ports 1 and 2.
- bit_index  out  $clog2(2*REG_BITS/NSHIFT)  current chunk index.
- a_in, b_in  in  NSHIFT  regfile scan_out / scan_out2 (operand a / operand b).
- scan_in, scan_in2  out  NSHIFT  result chunk / recirculated b chunk.
- flags  out  REG_BITS  {0..., V, S, Z, C}, with C = bit0, Z = bit1, S = bit2, V = bit3.

Behaviour:
- States: IDLE and RUN.
- Reset (asynchronous, any time, including mid-RUN):
  - state = IDLE, counter = 0, carry = 0, flags = 0.
  - All scan enables = 0, done = 0, ready = 1.
  - The partially scanned register is left rotated; correcting it is the caller's problem.
- IDLE:
  - ready = 1, do_scan = do_scan2 = 0, bit_index = 0.
  - start = 1 latches op, wide and no_wb, loads the initial carry and sets Z-accumulator = 1. The next cycle is RUN with count = 0.
  - Initial carry: ADD 0, ADC flags.C, SUB 1, SBC flags.C, others 0. Carry convention: C = NOT borrow.
- RUN:
  - ready = 0, do_scan = do_scan2 = 1, bit_index = count.
  - Last count L = REG_BITS/NSHIFT-1, or 2*REG_BITS/NSHIFT-1 when wide.
  - The caller selects the high register of the pair when bit_index >= REG_BITS/NSHIFT.
- Per-chunk datapath (combinational, same cycle):
  - b' = ~b_in for SUB/SBC, otherwise b_in.
  - res = ripple NSHIFT-bit add of a_in + b' + carry, or the bitwise function, or b_in for MOV.
  - scan_in = no_wb ? a_in : res.
  - scan_in2 = b_in, so operand b is preserved. When both ports address the same register, the regfile gives scan_in precedence.
- Per-chunk state update at each RUN edge:
  - carry <= chunk carry-out.
  - zacc <= zacc & (res == 0).
  - count++.
- Last chunk (count == L):
  - done = 1 for that cycle. The next state is IDLE and count returns to 0.
  - Flags update at that edge:
    - Arithmetic ops: C = final carry, Z = zacc & chunk zero, S = res MSB, V = carry into MSB XOR carry out of MSB.
    - Logic ops and MOV: C unchanged, V = 0, Z and S as above.
  - Flags upper bits are always 0.
- A start asserted during RUN is ignored and not queued.
- Latency: accept to done is REG_BITS/NSHIFT cycles (4), or 2x that when wide (8). Back-to-back: with start held high, the next command is accepted the cycle after done.

Decomposition:
- Shared package (common.vh) holds:
  - op encodings ALU_ADD..ALU_MOV;
  - flag bit positions FLAG_C=0, FLAG_Z=1, FLAG_S=2, FLAG_V=3;
  - state encodings.
- One sub-module, serial_alu_chunk: combinational NSHIFT-bit slice with inputs (a, b, cin, op) and outputs (res, cout, cmsb_in). The top holds the FSM, counter, carry, zacc and flags.

Test Plan:
- ADD, a=0x7F, b=0x01, flags=0 → 4 RUN cycles with bit_index 0..3; result register = 0x80; b unchanged; flags = 0x0C (S, V); done pulses on cycle 4.
- SUB, a=0x05, b=0x05 → result 0x00; flags = 0x03 (C=1 no borrow, Z=1). Then SBC 0x00-0x01 with C=1 → 0xFF; flags = 0x04 (C=0, S=1).
- wide ADD, a=0x00FF, b=0x0001 → 8 RUN cycles with bit_index 0..7; result 0x0100; flags = 0x00 (Z=0: the low zero byte must not set Z).
- no_wb SUB (CMP), a=0x10, b=0x20 → a stays 0x10; flags = 0x04 (C=0, S=1). AND 0xF0 & 0x0F with prior C=1 → 0x00; flags = 0x03.
- start pulsed at RUN count 1 → ignored: exactly one done, ready low until after done. start held high → a new accept on the cycle after each done.
- reset low at RUN count 2 → asynchronously IDLE: ready=1, do_scan=0, flags=0x00, done never pulses; a normal ADD works after release.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared op codes, flag bit positions and FSM states for the bit-serial ALU.
// Types and helpers only; no logic, latency or flow control lives here.
package serial_alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_ADC = 3'd1,
      ALU_SUB = 3'd2,
      ALU_SBC = 3'd3,
      ALU_AND = 3'd4,
      ALU_OR  = 3'd5,
      ALU_XOR = 3'd6,
      ALU_MOV = 3'd7
   } alu_op_t;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_S = 2;
   localparam int FLAG_V = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } alu_state_t;

   function automatic logic op_is_arith(input alu_op_t op);
      return (op == ALU_ADD) || (op == ALU_ADC) || (op == ALU_SUB) || (op == ALU_SBC);
   endfunction

   function automatic logic op_inverts_b(input alu_op_t op);
      return (op == ALU_SUB) || (op == ALU_SBC);
   endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Command handshake and regfile scan-port bundle between a sequencer caller and serial_alu.
// Caller drives start/op/operand chunks; the ALU drives ready/done/scan enables/results/flags.
interface serial_alu_if #(
   parameter int REG_BITS = 8,
   parameter int NSHIFT   = 2
);
   localparam int IDX_W = $clog2(2 * REG_BITS / NSHIFT);

   logic                start;
   logic [2:0]          op;
   logic                wide;
   logic                no_wb;
   logic                ready;
   logic                done;
   logic                do_scan;
   logic                do_scan2;
   logic [IDX_W-1:0]    bit_index;
   logic [NSHIFT-1:0]   a_in;
   logic [NSHIFT-1:0]   b_in;
   logic [NSHIFT-1:0]   scan_in;
   logic [NSHIFT-1:0]   scan_in2;
   logic [REG_BITS-1:0] flags;

   modport master (
      output start, op, wide, no_wb, a_in, b_in,
      input  ready, done, do_scan, do_scan2, bit_index, scan_in, scan_in2, flags
   );

   modport slave (
      input  start, op, wide, no_wb, a_in, b_in,
      output ready, done, do_scan, do_scan2, bit_index, scan_in, scan_in2, flags
   );

endinterface

// File: rtl/serial_alu_chunk.sv
// Combinational NSHIFT-bit ALU slice; zero latency, no flow control.
// cmsb_in is the carry into the slice MSB so the caller can form signed overflow.
module serial_alu_chunk
   import serial_alu_pkg::*;
#(
   parameter int NSHIFT = 2
) (
   input  logic [NSHIFT-1:0] a,
   input  logic [NSHIFT-1:0] b,
   input  logic              cin,
   input  alu_op_t           op,
   output logic [NSHIFT-1:0] res,
   output logic              cout,
   output logic              cmsb_in
);

   logic [NSHIFT-1:0] b_eff;
   logic [NSHIFT:0]   c;
   logic [NSHIFT-1:0] sum;

   always_comb begin
      b_eff = op_inverts_b(op) ? ~b : b;
      c     = '0;
      sum   = '0;
      c[0]  = cin;
      for (int i = 0; i < NSHIFT; i++) begin
         sum[i]   = a[i] ^ b_eff[i] ^ c[i];
         c[i+1]   = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
      end

      res = sum;
      case (op)
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_XOR: res = a ^ b;
         ALU_MOV: res = b;
         default: res = sum;
      endcase

      // Logic ops never propagate a carry between chunks.
      cout    = op_is_arith(op) ? c[NSHIFT]   : 1'b0;
      cmsb_in = op_is_arith(op) ? c[NSHIFT-1] : 1'b0;
   end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU sweeping a regfile operand pair NSHIFT bits/cycle, LSB first; REG_BITS/NSHIFT cycles per op (2x wide).
// ready only in IDLE; start during RUN is dropped, not queued; done pulses on the last chunk cycle.
module serial_alu
   import serial_alu_pkg::*;
#(
   parameter int REG_BITS = 8,
   parameter int NSHIFT   = 2
) (
   input  logic         clk,
   input  logic         reset,
   serial_alu_if.slave  bus
);

   localparam int CHUNKS = REG_BITS / NSHIFT;
   localparam int IDX_W  = $clog2(2 * CHUNKS);
   localparam logic [IDX_W-1:0] LAST_NARROW = IDX_W'(CHUNKS - 1);
   localparam logic [IDX_W-1:0] LAST_WIDE   = IDX_W'(2 * CHUNKS - 1);

   alu_state_t        state_q, state_d;
   logic [IDX_W-1:0]  count_q, count_d;
   logic              carry_q, carry_d;
   logic              zacc_q, zacc_d;
   logic [3:0]        flags_q, flags_d;
   alu_op_t           op_q, op_d;
   logic              wide_q, wide_d;
   logic              no_wb_q, no_wb_d;

   logic [NSHIFT-1:0] res;
   logic              cout;
   logic              cmsb_in;
   logic              last;
   logic              chunk_zero;

   serial_alu_chunk #(.NSHIFT(NSHIFT)) u_chunk (
      .a       (bus.a_in),
      .b       (bus.b_in),
      .cin     (carry_q),
      .op      (op_q),
      .res     (res),
      .cout    (cout),
      .cmsb_in (cmsb_in)
   );

   assign last       = (count_q == (wide_q ? LAST_WIDE : LAST_NARROW));
   assign chunk_zero = (res == '0);
   assign bus.flags  = {{(REG_BITS-4){1'b0}}, flags_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         carry_q <= 1'b0;
         zacc_q  <= 1'b0;
         flags_q <= '0;
         op_q    <= ALU_ADD;
         wide_q  <= 1'b0;
         no_wb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         carry_q <= carry_d;
         zacc_q  <= zacc_d;
         flags_q <= flags_d;
         op_q    <= op_d;
         wide_q  <= wide_d;
         no_wb_q <= no_wb_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      carry_d       = carry_q;
      zacc_d        = zacc_q;
      flags_d       = flags_q;
      op_d          = op_q;
      wide_d        = wide_q;
      no_wb_d       = no_wb_q;
      bus.ready     = 1'b0;
      bus.done      = 1'b0;
      bus.do_scan   = 1'b0;
      bus.do_scan2  = 1'b0;
      bus.bit_index = '0;
      // CMP/TEST write operand a back unchanged so the rotation restores it.
      bus.scan_in   = no_wb_q ? bus.a_in : res;
      bus.scan_in2  = bus.b_in;

      case (state_q)
         ST_IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) begin
               op_d    = alu_op_t'(bus.op);
               wide_d  = bus.wide;
               no_wb_d = bus.no_wb;
               zacc_d  = 1'b1;
               count_d = '0;
               state_d = ST_RUN;
               case (alu_op_t'(bus.op))
                  ALU_ADC, ALU_SBC: carry_d = flags_q[FLAG_C];
                  ALU_SUB:          carry_d = 1'b1;
                  default:          carry_d = 1'b0;
               endcase
            end
         end

         ST_RUN: begin
            bus.do_scan   = 1'b1;
            bus.do_scan2  = 1'b1;
            bus.bit_index = count_q;
            carry_d       = cout;
            zacc_d        = zacc_q & chunk_zero;
            count_d       = count_q + 1'b1;
            if (last) begin
               bus.done        = 1'b1;
               state_d         = ST_IDLE;
               count_d         = '0;
               flags_d[FLAG_Z] = zacc_q & chunk_zero;
               flags_d[FLAG_S] = res[NSHIFT-1];
               if (op_is_arith(op_q)) begin
                  flags_d[FLAG_C] = cout;
                  flags_d[FLAG_V] = cmsb_in ^ cout;
               end else begin
                  flags_d[FLAG_V] = 1'b0;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
